pe_mac: RTL and testbench
=========================

PE_MAC -- requirements
Module: pe_mac

Interface
REQ-001 SHALL have parameter DATA_W, default 8, activation/weight width (signed).
REQ-002 SHALL have parameter ACC_W, default 24, partial-sum width (signed), ACC_W >= 2*DATA_W.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port wen  input  1  load win into shadow weight.
REQ-006 SHALL have port wswap  input  1  copy shadow weight into active weight.
REQ-007 SHALL have port win  input  DATA_W  weight in.
REQ-008 SHALL have port wout  output  DATA_W  shadow weight, for the daisy-chain to the next PE.
REQ-009 SHALL have port os_mode  input  1  0 = weight-stationary pass-through sum, 1 = output-stationary local accumulate.
REQ-010 SHALL have port acc_clr  input  1  clear local accumulator.
REQ-011 SHALL have port ain, ain_valid  input  DATA_W/1  activation and its qualifier.
REQ-012 SHALL have port aout, aout_valid  output  DATA_W/1  registered activation forward.
REQ-013 SHALL have port psum_in  input  ACC_W  upstream partial sum.
REQ-014 SHALL have port psum_out, psum_valid  output  ACC_W/1  registered result.
REQ-015 SHALL have port sat_flag  output  1  sticky saturation indicator.

Function
REQ-016 SHALL load win into the shadow weight on a clk edge with wen=1; otherwise the shadow weight holds.
REQ-017 SHALL load shadow into active on a clk edge with wswap=1; when wen and wswap are both 1, active SHALL get the old shadow and shadow SHALL get win.
REQ-018 SHALL compute product = ain * active_weight as a full 2*DATA_W signed value, sign-extended to ACC_W.
REQ-019 SHALL, with ain_valid=1, register aout<=ain and aout_valid<=1 with one-cycle latency; with ain_valid=0, aout SHALL hold and aout_valid<=0.
REQ-020 SHALL, with os_mode=0 and ain_valid=1, register psum_out<=psum_in+product with psum_valid<=1 one cycle later.
REQ-021 SHALL, with os_mode=1 and ain_valid=1, update acc<=acc+product, with psum_out mirroring acc (psum_out<=acc+product) and psum_valid<=1.
REQ-022 SHALL, with ain_valid=0, hold psum_out and acc and drive psum_valid<=0.
REQ-023 SHALL give acc_clr priority: acc<=0 that cycle; acc_clr together with ain_valid SHALL give acc<=product (new accumulation start).
REQ-024 SHALL leave acc untouched in os_mode=0; a mode change SHALL take effect on the next valid beat.
REQ-025 SHALL use a weight swap in the same cycle as ain_valid only from the next cycle onward; the current beat SHALL use the pre-swap active weight.

Reset
REQ-026 SHALL clear shadow, active, acc, aout, psum_out and sat_flag to 0, and aout_valid and psum_valid to 0, immediately on reset_n low, independent of clk.
REQ-027 SHALL abandon any in-flight beat on reset assertion mid-operation; the first valid output after release SHALL come from post-release inputs only.

Configuration
REQ-028 SHALL use macro PE_MAC_SAT_EN: when defined, sums SHALL clamp to [-2^(ACC_W-1), 2^(ACC_W-1)-1] and sat_flag SHALL set on any clamp, cleared only by reset or acc_clr.
REQ-029 SHALL, without PE_MAC_SAT_EN, wrap sums modulo 2^ACC_W and tie sat_flag to 0.

Structure
REQ-030 SHALL place DATA_W/ACC_W defaults, the mode encoding constants and the saturation min/max helper constants in a shared package tpu_pkg.
REQ-031 SHALL put saturating/wrapping addition in sub-module pe_mac_add (ACC_W parameter, overflow output); all registers SHALL stay in pe_mac.

Verification
REQ-032 SHALL check: wen win=3, wswap; then ain=-4 valid, os_mode=0, psum_in=100 -> next cycle psum_out=88, psum_valid=1, aout=-4.
REQ-033 SHALL check: active=5, wen win=7 with wswap the same cycle, ain=2 valid -> psum_out=psum_in+10; the next beat uses weight 7 only after a further wswap (shadow=7, active=old shadow).
REQ-034 SHALL check: os_mode=1, acc_clr with ain=2 (w=6), then ain=3, 4 valid with a gap cycle -> psum_out 12, 30, 54; psum_valid low in the gap.
REQ-035 SHALL check, with DATA_W=8 and ACC_W=16, psum_in=32767 and product=1: with PE_MAC_SAT_EN -> psum_out=32767, sat_flag=1; without it -> psum_out=-32768, sat_flag=0.
REQ-036 SHALL check: reset_n pulsed low between clk edges mid-stream -> all outputs 0 immediately; the first post-release valid beat is correct.
REQ-037 SHALL check: -128*-128 with DATA_W=8, os_mode=0, psum_in=0 -> psum_out=16384 (no product truncation).

Source files
------------

// File: rtl/tpu_pkg.sv
// Shared constants for the TPU processing-element array: width defaults,
// dataflow mode encoding and saturation limit helpers.
package tpu_pkg;

    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned ACC_W_DEF  = 24;

    // Dataflow mode selected by os_mode
    typedef enum logic {
        MODE_WS = 1'b0,   // weight-stationary: add product to upstream psum
        MODE_OS = 1'b1    // output-stationary: accumulate locally
    } pe_mode_e;

    // Largest representable signed value of a w-bit word (w <= 64)
    function automatic logic signed [63:0] sat_max(input int unsigned w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    // Smallest representable signed value of a w-bit word (w <= 64)
    function automatic logic signed [63:0] sat_min(input int unsigned w);
        return -(64'sd1 <<< (w - 1));
    endfunction

endpackage

// File: rtl/pe_mac_add.sv
// Partial-sum adder for pe_mac. Purely combinational.
// PE_MAC_SAT_EN defined  : signed clamp to the ACC_W range, overflow flags a clamp.
// PE_MAC_SAT_EN undefined: two's-complement wrap, overflow tied low.
module pe_mac_add
    import tpu_pkg::*;
#(
    parameter int unsigned ACC_W = ACC_W_DEF
) (
    input  logic [ACC_W-1:0] a,
    input  logic [ACC_W-1:0] b,
    output logic [ACC_W-1:0] sum,
    output logic             overflow
);

`ifdef PE_MAC_SAT_EN
    localparam logic [ACC_W-1:0] MAX_V = ACC_W'(sat_max(ACC_W));
    localparam logic [ACC_W-1:0] MIN_V = ACC_W'(sat_min(ACC_W));

    logic [ACC_W:0] wide;

    // One guard bit; differing top two bits mean the signed result left the range
    always_comb begin
        wide     = {a[ACC_W-1], a} + {b[ACC_W-1], b};
        overflow = wide[ACC_W] ^ wide[ACC_W-1];
        sum      = wide[ACC_W-1:0];
        if (overflow) begin
            sum = wide[ACC_W] ? MIN_V : MAX_V;
        end
    end
`else
    // Modulo 2^ACC_W addition
    always_comb begin
        sum      = a + b;
        overflow = 1'b0;
    end
`endif

endmodule

// File: rtl/pe_mac.sv
// Systolic-array processing element: signed multiply-accumulate with a
// double-buffered weight (shadow/active), activation forwarding and either
// pass-through (weight-stationary) or local (output-stationary) summation.
// Optional feature macro: PE_MAC_SAT_EN enables saturating sums and sat_flag.
module pe_mac
    import tpu_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ACC_W  = ACC_W_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wen,
    input  logic              wswap,
    input  logic [DATA_W-1:0] win,
    output logic [DATA_W-1:0] wout,
    input  logic              os_mode,
    input  logic              acc_clr,
    input  logic [DATA_W-1:0] ain,
    input  logic              ain_valid,
    output logic [DATA_W-1:0] aout,
    output logic              aout_valid,
    input  logic [ACC_W-1:0]  psum_in,
    output logic [ACC_W-1:0]  psum_out,
    output logic              psum_valid,
    output logic              sat_flag
);

    localparam int unsigned PROD_W = 2 * DATA_W;

    logic [DATA_W-1:0] shadow_q, shadow_d;
    logic [DATA_W-1:0] active_q, active_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [DATA_W-1:0] aout_q, aout_d;
    logic              aout_valid_q, aout_valid_d;
    logic [ACC_W-1:0]  psum_q, psum_d;
    logic              psum_valid_q, psum_valid_d;
    logic              sat_q, sat_d;

    logic signed [PROD_W-1:0] prod_s;
    logic [ACC_W-1:0]         prod_ext;
    logic [ACC_W-1:0]         add_a;
    logic [ACC_W-1:0]         add_sum;
    logic                     add_ovf;
    logic                     is_os;

    // Full-width signed product of the pre-swap active weight, sign-extended
    always_comb begin
        prod_s   = $signed(ain) * $signed(active_q);
        prod_ext = ACC_W'(prod_s);
    end

    // Addend: upstream psum, or local acc (forced to zero when restarting)
    always_comb begin
        is_os = (os_mode == MODE_OS);
        add_a = psum_in;
        if (is_os) begin
            add_a = acc_clr ? '0 : acc_q;
        end
    end

    pe_mac_add #(
        .ACC_W(ACC_W)
    ) u_add (
        .a        (add_a),
        .b        (prod_ext),
        .sum      (add_sum),
        .overflow (add_ovf)
    );

    // Next-state for weights, activation forward, partial sum and accumulator
    always_comb begin
        shadow_d     = shadow_q;
        active_d     = active_q;
        acc_d        = acc_q;
        aout_d       = aout_q;
        psum_d       = psum_q;
        aout_valid_d = ain_valid;
        psum_valid_d = ain_valid;
        sat_d        = (sat_q & ~acc_clr) | (ain_valid & add_ovf);

        if (wen) begin
            shadow_d = win;
        end
        if (wswap) begin
            active_d = shadow_q;
        end

        if (acc_clr) begin
            acc_d = '0;
        end

        if (ain_valid) begin
            aout_d = ain;
            psum_d = add_sum;
            if (is_os) begin
                acc_d = add_sum;
            end
        end
    end

    // State registers, cleared asynchronously
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow_q     <= '0;
            active_q     <= '0;
            acc_q        <= '0;
            aout_q       <= '0;
            aout_valid_q <= 1'b0;
            psum_q       <= '0;
            psum_valid_q <= 1'b0;
            sat_q        <= 1'b0;
        end else begin
            shadow_q     <= shadow_d;
            active_q     <= active_d;
            acc_q        <= acc_d;
            aout_q       <= aout_d;
            aout_valid_q <= aout_valid_d;
            psum_q       <= psum_d;
            psum_valid_q <= psum_valid_d;
            sat_q        <= sat_d;
        end
    end

    assign wout       = shadow_q;
    assign aout       = aout_q;
    assign aout_valid = aout_valid_q;
    assign psum_out   = psum_q;
    assign psum_valid = psum_valid_q;
    assign sat_flag   = sat_q;

endmodule

// File: tb/tb_pe_mac.sv
// Self-checking bench for pe_mac (DATA_W=8, ACC_W=16): directed scenarios
// followed by randomized traffic against an integer reference model.
module tb_pe_mac;

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 16;
    localparam longint      HI = (longint'(1) <<< (AW - 1)) - 1;
    localparam longint      LO = -(longint'(1) <<< (AW - 1));
    localparam longint      MOD = longint'(1) <<< AW;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          wen, wswap, os_mode, acc_clr, ain_valid;
    logic [DW-1:0] win, ain;
    logic [AW-1:0] psum_in;
    logic [DW-1:0] wout, aout;
    logic          aout_valid, psum_valid, sat_flag;
    logic [AW-1:0] psum_out;

    always #5 clk = ~clk;

    pe_mac #(.DATA_W(DW), .ACC_W(AW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .wen        (wen),
        .wswap      (wswap),
        .win        (win),
        .wout       (wout),
        .os_mode    (os_mode),
        .acc_clr    (acc_clr),
        .ain        (ain),
        .ain_valid  (ain_valid),
        .aout       (aout),
        .aout_valid (aout_valid),
        .psum_in    (psum_in),
        .psum_out   (psum_out),
        .psum_valid (psum_valid),
        .sat_flag   (sat_flag)
    );

    int checks   = 0;
    int failures = 0;

    // Reference state, held as plain signed integers
    longint m_shadow, m_active, m_acc, m_aout, m_psum;
    bit     m_aout_v, m_psum_v, m_sat;

    task automatic chk(input string tag, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
        end
    endtask

    // Bring an arbitrary integer sum into the ACC_W result range
    function automatic longint fit(input longint s, output bit clamped);
        clamped = 1'b0;
`ifdef PE_MAC_SAT_EN
        if (s > HI) begin
            clamped = 1'b1;
            return HI;
        end
        if (s < LO) begin
            clamped = 1'b1;
            return LO;
        end
        return s;
`else
        return (((s - LO) % MOD) + MOD) % MOD + LO;
`endif
    endfunction

    function automatic longint sx_d(input logic [DW-1:0] v);
        return longint'($signed(v));
    endfunction

    function automatic longint sx_a(input logic [AW-1:0] v);
        return longint'($signed(v));
    endfunction

    task automatic model_reset();
        m_shadow = 0; m_active = 0; m_acc = 0; m_aout = 0; m_psum = 0;
        m_aout_v = 0; m_psum_v = 0; m_sat = 0;
    endtask

    // Apply one rising edge of the spec's behaviour to the reference model
    task automatic model_edge();
        longint prod, base, sum;
        bit     c;
        prod = sx_d(ain) * m_active;
        c    = 1'b0;
        if (ain_valid) begin
            if (os_mode) base = acc_clr ? 0 : m_acc;
            else         base = sx_a(psum_in);
            sum    = fit(base + prod, c);
            m_psum = sum;
            m_aout = sx_d(ain);
            if (os_mode)      m_acc = sum;
            else if (acc_clr) m_acc = 0;
        end else if (acc_clr) begin
            m_acc = 0;
        end
        m_sat    = (m_sat && !acc_clr) || c;
        m_aout_v = ain_valid;
        m_psum_v = ain_valid;
        if (wswap) m_active = m_shadow;
        if (wen)   m_shadow = sx_d(win);
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".psum_out"},   sx_a(psum_out), m_psum);
        chk({tag, ".psum_valid"}, longint'(psum_valid), longint'(m_psum_v));
        chk({tag, ".aout"},       sx_d(aout), m_aout);
        chk({tag, ".aout_valid"}, longint'(aout_valid), longint'(m_aout_v));
        chk({tag, ".wout"},       sx_d(wout), m_shadow);
        chk({tag, ".sat_flag"},   longint'(sat_flag), longint'(m_sat));
    endtask

    task automatic drive(input bit v, input longint a, input bit os, input longint pin,
                         input bit clr, input bit we, input longint w, input bit sw);
        ain_valid = v;
        ain       = DW'(a);
        os_mode   = os;
        psum_in   = AW'(pin);
        acc_clr   = clr;
        wen       = we;
        win       = DW'(w);
        wswap     = sw;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // One clock: model tracks the edge, outputs sampled 1ns later
    task automatic tick(input string tag);
        @(posedge clk);
        if (reset_n) model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic load_weight(input longint w);
        drive(0, 0, 0, 0, 0, 1, w, 0); tick("ldw");
        drive(0, 0, 0, 0, 0, 0, 0, 1); tick("swp");
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, ".psum_out"},   sx_a(psum_out), 0);
        chk({tag, ".psum_valid"}, longint'(psum_valid), 0);
        chk({tag, ".aout"},       sx_d(aout), 0);
        chk({tag, ".aout_valid"}, longint'(aout_valid), 0);
        chk({tag, ".wout"},       sx_d(wout), 0);
        chk({tag, ".sat_flag"},   longint'(sat_flag), 0);
    endtask

    initial begin
        reset_n = 1'b0;
        idle();
        model_reset();
        #12;
        check_zero_outputs("reset");
        @(negedge clk);
        reset_n = 1'b1;

        // Weight 3, ain=-4 with psum_in=100 -> 88
        load_weight(3);
        drive(1, -4, 0, 100, 0, 0, 0, 0); tick("wsdir");
        chk("wsdir.psum_lit", sx_a(psum_out), 88);
        chk("wsdir.valid_lit", longint'(psum_valid), 1);
        chk("wsdir.aout_lit", sx_d(aout), -4);

        // Swap in the same cycle as a beat uses the pre-swap weight
        load_weight(5);
        drive(1, 2, 0, 50, 0, 1, 7, 1); tick("swap0");
        chk("swap0.psum_lit", sx_a(psum_out), 60);
        drive(1, 2, 0, 50, 0, 0, 0, 0); tick("swap1");
        chk("swap1.psum_lit", sx_a(psum_out), 60);
        chk("swap1.wout_lit", sx_d(wout), 7);
        drive(0, 0, 0, 0, 0, 0, 0, 1); tick("swap2");
        drive(1, 2, 0, 50, 0, 0, 0, 0); tick("swap3");
        chk("swap3.psum_lit", sx_a(psum_out), 64);

        // Output-stationary accumulate with restart and a gap cycle
        load_weight(6);
        drive(1, 2, 1, 0, 1, 0, 0, 0); tick("os0");
        chk("os0.psum_lit", sx_a(psum_out), 12);
        drive(1, 3, 1, 0, 0, 0, 0, 0); tick("os1");
        chk("os1.psum_lit", sx_a(psum_out), 30);
        drive(0, 0, 1, 0, 0, 0, 0, 0); tick("osgap");
        chk("osgap.valid_lit", longint'(psum_valid), 0);
        drive(1, 4, 1, 0, 0, 0, 0, 0); tick("os2");
        chk("os2.psum_lit", sx_a(psum_out), 54);

        // Positive overflow boundary
        load_weight(1);
        drive(1, 1, 0, 32767, 0, 0, 0, 0); tick("ovf");
`ifdef PE_MAC_SAT_EN
        chk("ovf.psum_lit", sx_a(psum_out), 32767);
        chk("ovf.sat_lit", longint'(sat_flag), 1);
`else
        chk("ovf.psum_lit", sx_a(psum_out), -32768);
        chk("ovf.sat_lit", longint'(sat_flag), 0);
`endif
        drive(0, 0, 0, 0, 1, 0, 0, 0); tick("satclr");
        chk("satclr.sat_lit", longint'(sat_flag), 0);

        // Most negative operands: no product truncation
        load_weight(-128);
        drive(1, -128, 0, 0, 0, 0, 0, 0); tick("minmul");
        chk("minmul.psum_lit", sx_a(psum_out), 16384);

        // Asynchronous reset mid-stream
        load_weight(9);
        drive(1, 3, 0, 5, 0, 1, 4, 0); tick("pre_rst0");
        drive(1, 7, 1, 11, 0, 0, 0, 1); tick("pre_rst1");
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_zero_outputs("rst_async");
        @(posedge clk);
        #1;
        check_zero_outputs("rst_held");
        #2;
        reset_n = 1'b1;
        drive(1, 5, 0, 77, 0, 0, 0, 0); tick("post_rst");
        chk("post_rst.psum_lit", sx_a(psum_out), 77);
        chk("post_rst.aout_lit", sx_d(aout), 5);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 9) < 7,
                  longint'($signed(DW'($urandom))),
                  $urandom_range(0, 1) == 1,
                  longint'($signed(AW'($urandom))),
                  $urandom_range(0, 15) == 0,
                  $urandom_range(0, 3) == 0,
                  longint'($signed(DW'($urandom))),
                  $urandom_range(0, 4) == 0);
            tick("rand");
        end

        idle();
        tick("final");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time guard
    initial begin
        #200000;
        $display("FAIL timeout got=%0d exp=%0d", checks, 0);
        $fatal(1, "bench timed out");
    end

endmodule
